cmp_bist: RTL and testbench

- Hardware self-test engine for small combinational comparators (equality / greater-than, N-bit).
- Sits on the driving side of a comparator: generates every operand pair exhaustively, waits a settle interval, samples the comparator's eq/gt outputs and checks them against internally computed expected values.
- Reports pass/fail, the failure count and the first failing vector.
- Runs on-chip or in simulation, in place of a hand-written stimulus bench.

---
 rtl/cmp_bist.sv | 154 +++++++++++++++
 tb/tb_cmp_bist.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_bist.sv
// ---------------------------------------------------------------------------
// cmp_bist -- exhaustive self-test engine for an N-bit eq/gt comparator.
//
// Walks every operand pair (a = vec[2N-1:N], b = vec[N-1:0], b fastest),
// holds each pair for SETTLE cycles, then samples the comparator's eq/gt
// results for one CHECK cycle and compares them with the unsigned reference
// (a==b, a>b). Counts failing vectors and captures the first failing pair.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             launch a run (honoured only in IDLE or DONE)
//   a, b              operands driven to the comparator (0 when not running)
//   dut_eq, dut_gt    comparator results, sampled only in CHECK
//   busy              run in progress
//   done              run complete (level until next start or reset)
//   pass              done && no failures
//   err_count         number of failing vectors in the current/last run
//   fail_valid        at least one failure recorded
//   fail_a, fail_b    operands of the first failing vector
//   state_dbg         current FSM state (IDLE=0, DRIVE=1, CHECK=2, DONE=3)
//
// Handshake: start is a level sampled at each rising edge; while busy it is
// ignored (no restart, no queuing). done/pass/err_count/fail_* are stable
// from the cycle done rises until the next accepted start or reset.
// ---------------------------------------------------------------------------
module cmp_bist #(
   parameter int N      = 2,
   parameter int SETTLE = 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   output logic [N-1:0]   a,
   output logic [N-1:0]   b,
   input  logic           dut_eq,
   input  logic           dut_gt,
   output logic           busy,
   output logic           done,
   output logic           pass,
   output logic [2*N:0]   err_count,
   output logic           fail_valid,
   output logic [N-1:0]   fail_a,
   output logic [N-1:0]   fail_b,
   output logic [1:0]     state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Settle counter runs 0..SETTLE-1; keep at least one bit.
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   state_t          state;
   state_t          state_nxt;
   logic [2*N-1:0]  vec;
   logic [SW-1:0]   settle_cnt;
   logic [N-1:0]    vec_a;
   logic [N-1:0]    vec_b;
   logic            settle_last;
   logic            vec_last;
   logic            exp_eq;
   logic            exp_gt;
   logic            mismatch;
   logic            launch;

   assign vec_a       = vec[2*N-1:N];
   assign vec_b       = vec[N-1:0];
   assign settle_last = (settle_cnt == SW'(SETTLE - 1));
   assign vec_last    = &vec;
   assign exp_eq      = (vec_a == vec_b);
   assign exp_gt      = (vec_a > vec_b);
   // A vector failing on both bits still counts as a single failure.
   assign mismatch    = (dut_eq != exp_eq) || (dut_gt != exp_gt);
   assign launch      = start && ((state == IDLE) || (state == DONE));

   // ---------------- FSM state register ----------------
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // ---------------- FSM next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = DRIVE;
         DRIVE:   if (settle_last) state_nxt = CHECK;
         CHECK:   state_nxt = vec_last ? DONE : DRIVE;
         DONE:    if (start) state_nxt = DRIVE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         vec        <= '0;
         settle_cnt <= '0;
         err_count  <= '0;
         fail_valid <= 1'b0;
         fail_a     <= '0;
         fail_b     <= '0;
      end else if (launch) begin
         vec        <= '0;
         settle_cnt <= '0;
         err_count  <= '0;
         fail_valid <= 1'b0;
         fail_a     <= '0;
         fail_b     <= '0;
      end else begin
         case (state)
            DRIVE: settle_cnt <= settle_last ? '0 : settle_cnt + SW'(1);
            CHECK: begin
               if (mismatch) begin
                  err_count <= err_count + (2*N+1)'(1);
                  if (!fail_valid) begin
                     fail_valid <= 1'b1;
                     fail_a     <= vec_a;
                     fail_b     <= vec_b;
                  end
               end
               // Counter stays at all-ones in DONE; cleared on next launch.
               if (!vec_last) vec <= vec + (2*N)'(1);
            end
            default: ;
         endcase
      end
   end

   // ---------------- outputs ----------------
   always_comb begin
      a    = '0;
      b    = '0;
      busy = 1'b0;
      done = 1'b0;
      case (state)
         DRIVE, CHECK: begin
            a    = vec_a;
            b    = vec_b;
            busy = 1'b1;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   assign pass      = done && (err_count == '0);
   assign state_dbg = state;

endmodule

// File: tb/tb_cmp_bist.sv
// ---------------------------------------------------------------------------
// tb_cmp_bist -- bench for cmp_bist (N=2, SETTLE=1).
// A behavioural comparator (ideal or with injected faults) answers the
// engine's operands; a reference model walks all vectors arithmetically to
// predict err_count and the first failing pair.
// ---------------------------------------------------------------------------
module tb_cmp_bist;

   localparam int N      = 2;
   localparam int SETTLE = 1;
   localparam int NB     = 1 << N;
   localparam int V      = 1 << (2 * N);

   // ---------------- clock / reset / DUT ----------------
   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           dut_eq;
   logic           dut_gt;
   logic           busy;
   logic           done;
   logic           pass;
   logic [2*N:0]   err_count;
   logic           fail_valid;
   logic [N-1:0]   fail_a;
   logic [N-1:0]   fail_b;
   logic [1:0]     state_dbg;

   always #5 clk = ~clk;

   cmp_bist #(.N(N), .SETTLE(SETTLE)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .a          (a),
      .b          (b),
      .dut_eq     (dut_eq),
      .dut_gt     (dut_gt),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .err_count  (err_count),
      .fail_valid (fail_valid),
      .fail_a     (fail_a),
      .fail_b     (fail_b),
      .state_dbg  (state_dbg)
   );

   // ---------------- comparator model under test ----------------
   // mode 0 ideal, 1 eq stuck 0, 2 gt wrong at 2/3, 3 gt inverted + eq wrong
   // at 1/1, 4 random per-vector flips from fault_eq/fault_gt.
   int          mode;
   logic [V-1:0] fault_eq;
   logic [V-1:0] fault_gt;

   function automatic logic [1:0] cmp_out(input int m, input int av, input int bv,
                                          input logic [V-1:0] feq, input logic [V-1:0] fgt);
      logic eq;
      logic gt;
      int   idx;
      idx = av * NB + bv;
      eq  = (av == bv);
      gt  = (av > bv);
      case (m)
         1: eq = 1'b0;
         2: if (av == 2 && bv == 3) gt = 1'b1;
         3: begin
            gt = !gt;
            if (av == 1 && bv == 1) eq = !eq;
         end
         4: begin
            eq = eq ^ feq[idx];
            gt = gt ^ fgt[idx];
         end
         default: ;
      endcase
      return {eq, gt};
   endfunction

   assign {dut_eq, dut_gt} = cmp_out(mode, int'(a), int'(b), fault_eq, fault_gt);

   // ---------------- reference model ----------------
   task automatic ref_model(output int exp_err, output int exp_fv,
                            output int exp_fa, output int exp_fb);
      logic [1:0] got;
      exp_err = 0; exp_fv = 0; exp_fa = 0; exp_fb = 0;
      for (int idx = 0; idx < V; idx++) begin
         int av = idx / NB;
         int bv = idx % NB;
         got = cmp_out(mode, av, bv, fault_eq, fault_gt);
         if (got != {av == bv, av > bv}) begin
            exp_err++;
            if (exp_fv == 0) begin
               exp_fv = 1; exp_fa = av; exp_fb = bv;
            end
         end
      end
   endtask

   // ---------------- scoreboard ----------------
   int tests_run = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input int got, input int exp);
      tests_run++;
      if (got != exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_a"},     int'(a), 0);
      check({tag, "_b"},     int'(b), 0);
      check({tag, "_busy"},  int'(busy), 0);
      check({tag, "_done"},  int'(done), 0);
      check({tag, "_pass"},  int'(pass), 0);
      check({tag, "_err"},   int'(err_count), 0);
      check({tag, "_fv"},    int'(fail_valid), 0);
      check({tag, "_fa"},    int'(fail_a), 0);
      check({tag, "_fb"},    int'(fail_b), 0);
      check({tag, "_state"}, int'(state_dbg), 0);
   endtask

   // ---------------- driver: one full run ----------------
   // retrig_at: busy-cycle index at which start is re-pulsed (-1 = never).
   task automatic do_run(input string tag, input int retrig_at);
      int exp_err, exp_fv, exp_fa, exp_fb;
      int bc;
      int seen_done;
      ref_model(exp_err, exp_fv, exp_fa, exp_fb);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check({tag, "_launch_done"}, int'(done), 0);
      check({tag, "_launch_err"},  int'(err_count), 0);
      check({tag, "_launch_fv"},   int'(fail_valid), 0);
      bc = 0;
      seen_done = 0;
      for (int c = 0; c < 200 && seen_done == 0; c++) begin
         if (done) begin
            seen_done = 1;
         end else begin
            int idx = bc / (SETTLE + 1);
            check({tag, "_busy"}, int'(busy), 1);
            check({tag, "_a"},    int'(a), idx / NB);
            check({tag, "_b"},    int'(b), idx % NB);
            check({tag, "_pass"}, int'(pass), 0);
            bc++;
            start = (bc == retrig_at);
            @(negedge clk);
         end
      end
      start = 1'b0;
      check({tag, "_done_seen"},   seen_done, 1);
      check({tag, "_busy_cycles"}, bc, V * (SETTLE + 1));
      check({tag, "_busy_end"},    int'(busy), 0);
      check({tag, "_a_end"},       int'(a), 0);
      check({tag, "_b_end"},       int'(b), 0);
      check({tag, "_state_end"},   int'(state_dbg), 3);
      repeat (2) @(negedge clk);
      check({tag, "_done_hold"},   int'(done), 1);
      check({tag, "_pass"},        int'(pass), (exp_err == 0) ? 1 : 0);
      check({tag, "_err"},         int'(err_count), exp_err);
      check({tag, "_fv"},          int'(fail_valid), exp_fv);
      check({tag, "_fa"},          int'(fail_a), exp_fa);
      check({tag, "_fb"},          int'(fail_b), exp_fb);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin
      reset = 1'b1; start = 1'b0; mode = 0;
      fault_eq = '0; fault_gt = '0;
      repeat (3) @(negedge clk);
      check_idle_zero("reset");
      reset = 1'b0;
      @(negedge clk);
      check_idle_zero("idle");

      // Directed comparator models.
      mode = 0; do_run("ideal", -1);
      mode = 1; do_run("eq_stuck0", -1);
      mode = 2; do_run("gt_23", -1);
      mode = 3; do_run("gt_inv", -1);

      // start while busy is ignored; then relaunch straight from DONE.
      mode = 0; do_run("retrig", 10);
      mode = 2; do_run("from_done", -1);

      // Reset in the middle of a run.
      mode = 1;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (14) @(negedge clk);
      check("midrun_busy", int'(busy), 1);
      reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      check_idle_zero("midrun_reset");
      mode = 0; do_run("after_reset", -1);

      // Randomised fault patterns, idle gaps and stray start pulses.
      for (int r = 0; r < 6; r++) begin
         mode = 4;
         fault_eq = V'($urandom) & V'($urandom);
         fault_gt = V'($urandom) & V'($urandom) & V'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         do_run("random", ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 30)) : -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
